uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the SoC's UART transmitter.
- Samples the asynchronous uart_rxd pin (uio_in[5]) and assembles bytes LSB-first.
- Holds the last good byte in a one-entry buffer with ready/overrun flags, for a memory-mapped read port (CPU reads byte at 0x10000104, status at 0x10000108).
- Also reports frame errors and break conditions.

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Host-side signal bundle for the 8N1 UART receiver: serial line, enable,
// read strobe, and the buffered byte with its status flags.
interface uart_rx_if;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       rx_ack;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       rx_ready;
    logic       rx_overrun;
    logic       frame_err;
    logic       uart_rx_break;
    logic       rx_busy;

    modport slave (
        input  uart_rxd, uart_rx_en, rx_ack,
        output uart_rx_valid, uart_rx_data, rx_ready, rx_overrun,
               frame_err, uart_rx_break, rx_busy
    );

    modport master (
        output uart_rxd, uart_rx_en, rx_ack,
        input  uart_rx_valid, uart_rx_data, rx_ready, rx_overrun,
               frame_err, uart_rx_break, rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, samples mid-bit, and keeps the
// last good byte in a one-entry buffer with ready/overrun/frame/break status.
module uart_rx #(
    parameter int CLK_HZ   = 24_000_000,
    parameter int BIT_RATE = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    uart_rx_if.slave    bus
);
    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK, S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rxd_meta;
    logic             r_rxd_s;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ready;
    logic             r_overrun;
    logic             r_frame_err;
    logic             w_bit_tick;
    logic             w_good;
    logic             w_bad;

    always_comb begin
        w_state_nxt = r_state;
        w_bit_tick  = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        if (!bus.uart_rx_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (!r_rxd_s) w_state_nxt = S_START;
                S_START: begin
                    if (r_cnt == HALF_LAST)
                        w_state_nxt = r_rxd_s ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (r_cnt == FULL_LAST) begin
                        w_bit_tick = 1'b1;
                        if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        if (r_rxd_s) begin
                            w_good      = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_bad       = 1'b1;
                            w_state_nxt = (r_shift == 8'h00) ? S_BREAK : S_WAIT_IDLE;
                        end
                    end
                end
                S_BREAK, S_WAIT_IDLE: if (r_rxd_s) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_meta  <= 1'b1;
            r_rxd_s     <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_ready     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rxd_meta  <= bus.uart_rxd;
            r_rxd_s     <= r_rxd_meta;
            r_state     <= w_state_nxt;
            r_valid     <= w_good;
            r_frame_err <= w_bad;

            // Count only in the timed states; any state change or bit boundary restarts it.
            if (w_state_nxt != r_state || w_bit_tick)
                r_cnt <= '0;
            else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP)
                r_cnt <= r_cnt + 1'b1;

            if (r_state == S_START && w_state_nxt == S_DATA)
                r_bit_idx <= 3'd0;
            if (w_bit_tick) begin
                r_shift[r_bit_idx] <= r_rxd_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end

            // Newest byte always wins; an ack in the same cycle keeps the buffer full.
            if (w_good) begin
                r_data  <= r_shift;
                r_ready <= 1'b1;
                if (bus.rx_ack)
                    r_overrun <= 1'b0;
                else if (r_ready)
                    r_overrun <= 1'b1;
            end else if (bus.rx_ack && r_ready) begin
                r_ready   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.uart_rx_valid = r_valid;
    assign bus.uart_rx_data  = r_data;
    assign bus.rx_ready      = r_ready;
    assign bus.rx_overrun    = r_overrun;
    assign bus.frame_err     = r_frame_err;
    assign bus.uart_rx_break = (r_state == S_BREAK);
    assign bus.rx_busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 208 clocks per bit: table of frames plus
// hand-written latency, glitch, break, reset and enable-drop sequences.
module tb_uart_rx;
    localparam int BIT = 208;

    logic clk;
    logic rst;
    uart_rx_if u_if ();

    uart_rx #(.CLK_HZ(24_000_000), .BIT_RATE(115_200)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_valid  = 0;
    int n_wide   = 0;
    int n_ferr   = 0;
    int n_brk    = 0;
    int last_valid_cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (u_if.uart_rx_valid === 1'b1) begin
            n_valid = n_valid + 1;
            last_valid_cyc = cyc;
            if (prev_valid) n_wide = n_wide + 1;
        end
        prev_valid = (u_if.uart_rx_valid === 1'b1);
        if (u_if.frame_err === 1'b1) n_ferr = n_ferr + 1;
        if (u_if.uart_rx_break === 1'b1) n_brk = n_brk + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic b, input int n);
        u_if.uart_rxd = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        u_if.rx_ack = 1'b1;
        @(posedge clk);
        #1;
        u_if.rx_ack = 1'b0;
    endtask

    // ack_mode: 0 none, 1 ack well after the valid pulse, 2 ack in the stop-sample cycle
    task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_mode);
        logic [7:0] v;
        v = d;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(v[i], BIT);
        case (ack_mode)
            1: begin hold(stop, 150); pulse_ack(); hold(stop, 57); end
            2: begin hold(stop, 106); pulse_ack(); hold(stop, 101); end
            default: hold(stop, BIT);
        endcase
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        logic [7:0] v;
        v = d;
        hold(1'b0, BIT);
        for (int i = 0; i < nbits; i++) hold(v[i], BIT);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         ack_mode;
        int         gap;
        int         dv;
        int         df;
        logic [7:0] ed;
        logic       er;
        logic       eo;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int t0, v0, f0, b0, k;
        string tag;

        vecs[0] = '{8'h00, 1'b1, 1, 0, 1, 0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1, 0, 1, 0, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{8'hA3, 1'b1, 1, 0, 1, 0, 8'hA3, 1'b0, 1'b0};
        vecs[3] = '{8'h12, 1'b1, 0, 0, 1, 0, 8'h12, 1'b1, 1'b0};
        vecs[4] = '{8'h34, 1'b1, 0, 0, 1, 0, 8'h34, 1'b1, 1'b1};
        vecs[5] = '{8'h88, 1'b1, 2, 0, 1, 0, 8'h88, 1'b1, 1'b0};
        vecs[6] = '{8'hC3, 1'b0, 0, 0, 0, 1, 8'h88, 1'b1, 1'b0};

        rst = 1'b1;
        u_if.uart_rxd   = 1'b1;
        u_if.uart_rx_en = 1'b1;
        u_if.rx_ack     = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, 10);

        chk("reset_data",  32'(u_if.uart_rx_data), 32'h00);
        chk("reset_ready", 32'(u_if.rx_ready), 32'h0);
        chk("reset_ovr",   32'(u_if.rx_overrun), 32'h0);
        chk("reset_busy",  32'(u_if.rx_busy), 32'h0);
        chk("reset_break", 32'(u_if.uart_rx_break), 32'h0);
        chk("reset_pulses", 32'(n_valid + n_ferr), 32'h0);

        // First frame: latency from the pin falling edge to the valid pulse.
        t0 = cyc;
        send_frame(8'h55, 1'b1, 0);
        n_checks = n_checks + 1;
        if (n_valid != 1 || (last_valid_cyc - t0) < 1979 || (last_valid_cyc - t0) > 1981) begin
            n_fail = n_fail + 1;
            $display("FAIL latency_55: got %0d valid pulses at %0d cycles, required 1 pulse at 1979..1981",
                     n_valid, last_valid_cyc - t0);
        end
        chk("data_55",  32'(u_if.uart_rx_data), 32'h55);
        chk("ready_55", 32'(u_if.rx_ready), 32'h1);
        chk("ferr_55",  32'(n_ferr), 32'h0);
        pulse_ack();
        chk("ack_ready", 32'(u_if.rx_ready), 32'h0);
        chk("ack_data_hold", 32'(u_if.uart_rx_data), 32'h55);

        for (int i = 0; i < 7; i++) begin
            v0 = n_valid;
            f0 = n_ferr;
            send_frame(vecs[i].d, vecs[i].stop, vecs[i].ack_mode);
            if (vecs[i].gap > 0) hold(1'b1, vecs[i].gap);
            tag = $sformatf("vec%0d", i);
            chk({tag, "_valid_n"}, 32'(n_valid - v0), 32'(vecs[i].dv));
            chk({tag, "_ferr_n"},  32'(n_ferr - f0),  32'(vecs[i].df));
            chk({tag, "_data"},    32'(u_if.uart_rx_data), 32'(vecs[i].ed));
            chk({tag, "_ready"},   32'(u_if.rx_ready),     32'(vecs[i].er));
            chk({tag, "_ovr"},     32'(u_if.rx_overrun),   32'(vecs[i].eo));
        end

        // Bad stop with nonzero data: long low line must not look like a break.
        b0 = n_brk;
        hold(1'b0, 3000);
        chk("hold_low_break", 32'(n_brk - b0), 32'h0);
        chk("hold_low_busy",  32'(u_if.rx_busy), 32'h1);
        hold(1'b1, 10);
        chk("hold_low_idle",  32'(u_if.rx_busy), 32'h0);
        v0 = n_valid;
        send_frame(8'h0F, 1'b1, 1);
        chk("after_err_valid_n", 32'(n_valid - v0), 32'h1);
        chk("after_err_data",    32'(u_if.uart_rx_data), 32'h0F);
        chk("after_err_ready",   32'(u_if.rx_ready), 32'h0);
        chk("after_err_ovr",     32'(u_if.rx_overrun), 32'h0);

        // Start-bit glitch.
        v0 = n_valid;
        f0 = n_ferr;
        hold(1'b0, 50);
        u_if.uart_rxd = 1'b1;
        k = 0;
        while (u_if.rx_busy === 1'b1 && k < 110) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("glitch_idle", 32'(u_if.rx_busy), 32'h0);
        hold(1'b1, 20);
        chk("glitch_pulses", 32'((n_valid - v0) + (n_ferr - f0)), 32'h0);

        // Break: line low for 12 bit-times.
        v0 = n_valid;
        f0 = n_ferr;
        hold(1'b0, 12 * BIT);
        chk("break_high", 32'(u_if.uart_rx_break), 32'h1);
        chk("break_ferr_n", 32'(n_ferr - f0), 32'h1);
        chk("break_valid_n", 32'(n_valid - v0), 32'h0);
        u_if.uart_rxd = 1'b1;
        k = 0;
        while (u_if.uart_rx_break === 1'b1 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("break_clear", 32'(u_if.uart_rx_break), 32'h0);
        chk("break_clear_delay_ok", 32'(k <= 4), 32'h1);
        chk("break_data_hold", 32'(u_if.uart_rx_data), 32'h0F);
        hold(1'b1, 5);

        // Reset mid-frame.
        send_partial(8'h99, 3);
        rst = 1'b1;
        u_if.uart_rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_data",  32'(u_if.uart_rx_data), 32'h00);
        chk("midrst_ready", 32'(u_if.rx_ready), 32'h0);
        chk("midrst_busy",  32'(u_if.rx_busy), 32'h0);
        chk("midrst_flags", 32'({u_if.rx_overrun, u_if.frame_err, u_if.uart_rx_break, u_if.uart_rx_valid}), 32'h0);
        hold(1'b1, 5);
        send_frame(8'h5A, 1'b1, 0);
        chk("post_rst_data",  32'(u_if.uart_rx_data), 32'h5A);
        chk("post_rst_ready", 32'(u_if.rx_ready), 32'h1);

        // Enable dropped mid-frame.
        v0 = n_valid;
        f0 = n_ferr;
        send_partial(8'h81, 4);
        u_if.uart_rx_en = 1'b0;
        u_if.uart_rxd   = 1'b1;
        @(posedge clk);
        #1;
        chk("en_drop_busy", 32'(u_if.rx_busy), 32'h0);
        hold(1'b1, 3);
        u_if.uart_rx_en = 1'b1;
        chk("en_drop_data",  32'(u_if.uart_rx_data), 32'h5A);
        chk("en_drop_ready", 32'(u_if.rx_ready), 32'h1);
        chk("en_drop_pulses", 32'((n_valid - v0) + (n_ferr - f0)), 32'h0);
        hold(1'b1, 5);
        send_frame(8'hE7, 1'b1, 1);
        chk("post_en_valid_n", 32'(n_valid - v0), 32'h1);
        chk("post_en_data",  32'(u_if.uart_rx_data), 32'hE7);
        chk("post_en_ready", 32'(u_if.rx_ready), 32'h0);
        chk("post_en_ovr",   32'(u_if.rx_overrun), 32'h0);

        chk("valid_single_cycle", 32'(n_wide), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
